// File: rtl/dac_sample_scheduler.sv
// Paced round-robin arbiter sharing one AD5541A SPI DAC driver between N_SRC
// AXI-stream sample sources; one update slot every CLK_DIV mclk cycles.
//
// state | meaning
// IDLE  | waiting for a slot tick; arbitrates among eligible valid sources
// SEND  | holding a captured sample on m_axis until the driver accepts it
module dac_sample_scheduler #(
  parameter int N_SRC   = 4,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 500
) (
  input  logic                       mclk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_SRC-1:0]           src_mask,
  input  logic [N_SRC-1:0]           s_axis_valid,
  output logic [N_SRC-1:0]           s_axis_ready,
  input  logic [N_SRC*DATA_W-1:0]    s_axis_data,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic [DATA_W-1:0]          m_axis_data,
  output logic [$clog2(N_SRC)-1:0]   grant_idx,
  output logic                       dac_en,
  output logic [15:0]                underrun_cnt,
  output logic [15:0]                overrun_cnt
);

  localparam int IW = $clog2(N_SRC);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] SRC_MAX = IW'(N_SRC - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_cnt;
  logic [IW-1:0]       last_q;
  logic [DATA_W-1:0]   hold_q;
  logic                en_q;
  logic                tick;
  logic [N_SRC-1:0]    req;
  logic [IW-1:0]       cand;
  logic [IW-1:0]       win_idx;
  logic                win_found;
  logic                grant;
  logic                underrun_evt;
  logic                overrun_evt;

  assign tick = en & ~rst & (div_cnt == DIV_MAX);
  assign req  = s_axis_valid & src_mask;

  // Round-robin search starting just after the last winner, wrapping at N_SRC.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_q;
    for (int k = 0; k < N_SRC; k++) begin
      cand = (cand == SRC_MAX) ? '0 : cand + 1'b1;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    s_axis_ready = '0;
    underrun_evt = 1'b0;
    overrun_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (win_found) begin
            grant                 = 1'b1;
            s_axis_ready[win_idx] = 1'b1;
            state_d               = SEND;
          end else begin
            underrun_evt = 1'b1;
          end
        end
      end
      SEND: begin
        // A slot landing during a pending transfer is lost, even on the accept cycle.
        overrun_evt = tick;
        if (m_axis_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt      <= '0;
      last_q       <= SRC_MAX;
      hold_q       <= '0;
      grant_idx    <= '0;
      en_q         <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + 1'b1;
      if (grant) begin
        hold_q    <= s_axis_data[int'(win_idx)*DATA_W +: DATA_W];
        last_q    <= win_idx;
        grant_idx <= win_idx;
      end
      if (underrun_evt && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      if (overrun_evt && overrun_cnt != 16'hFFFF)   overrun_cnt  <= overrun_cnt + 16'd1;
    end
  end

  assign m_axis_valid = (state_q == SEND);
  assign m_axis_data  = hold_q;
  assign dac_en       = en_q | (state_q == SEND);

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: N_SRC=4, CLK_DIV=8, driver model
// accepts a pending sample after ready_delay cycles.
module tb_dac_sample_scheduler;
  localparam int N_SRC = 4;
  localparam int DATA_W = 16;
  localparam int CLK_DIV = 8;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  src_mask = 4'hF;
  logic [3:0]  s_axis_valid = 4'h0;
  logic [3:0]  s_axis_ready;
  logic [63:0] s_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready = 1'b0;
  logic [15:0] m_axis_data;
  logic [1:0]  grant_idx;
  logic        dac_en;
  logic [15:0] underrun_cnt, overrun_cnt;

  int n_cmp = 0, n_err = 0, cyc = 0, ready_delay = 2, wait_cnt = 0, last_at = 0;
  logic [3:0] ready_seen = 4'h0;
  logic       valid_seen = 1'b0;

  dac_sample_scheduler #(.N_SRC(N_SRC), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .mclk(mclk), .rst(rst), .en(en), .src_mask(src_mask),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
    .grant_idx(grant_idx), .dac_en(dac_en),
    .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt));

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  // Driver model: raise m_axis_ready once valid has been pending ready_delay cycles.
  initial forever begin
    @(negedge mclk);
    if (m_axis_valid && !m_axis_ready) begin
      wait_cnt++;
      if (wait_cnt >= ready_delay) m_axis_ready = 1'b1;
    end else begin
      m_axis_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  initial forever begin
    @(negedge mclk);
    ready_seen = ready_seen | s_axis_ready;
    if (m_axis_valid) valid_seen = 1'b1;
  end

  task automatic wait_grant(input int budget, output logic [3:0] rdy, output int at, output bit ok);
    ok = 1'b0; rdy = 4'h0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge mclk);
      if (s_axis_ready != 4'h0) begin
        rdy = s_axis_ready; at = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mclk);
    n_cmp++; if (s_axis_ready !== 4'h0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0000", s_axis_ready); end
    n_cmp++; if (m_axis_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_axis_valid); end
    n_cmp++; if (m_axis_data !== 16'h0) begin n_err++; $display("FAIL rst_m_data: got %h want 0000", m_axis_data); end
    n_cmp++; if (dac_en !== 1'b0) begin n_err++; $display("FAIL rst_dac_en: got %b want 0", dac_en); end
    n_cmp++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL rst_grant_idx: got %0d want 0", grant_idx); end
    n_cmp++; if (underrun_cnt !== 16'd0) begin n_err++; $display("FAIL rst_underrun: got %0d want 0", underrun_cnt); end
    n_cmp++; if (overrun_cnt !== 16'd0) begin n_err++; $display("FAIL rst_overrun: got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy; int at, c0, e; bit ok;
    s_axis_valid = 4'hF; src_mask = 4'hF;
    @(negedge mclk); rst = 1'b0; en = 1'b1; c0 = cyc; last_at = c0 - 1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      wait_grant(20, rdy, at, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout: slot %0d got no grant want grant", k); end
      n_cmp++; if (rdy !== (4'b0001 << e)) begin n_err++; $display("FAIL rr_ready: slot %0d got %b want %b", k, rdy, 4'b0001 << e); end
      n_cmp++; if (at - last_at !== 8) begin n_err++; $display("FAIL rr_period: slot %0d got %0d want 8", k, at - last_at); end
      last_at = at;
      @(negedge mclk);
      n_cmp++; if (m_axis_valid !== 1'b1) begin n_err++; $display("FAIL rr_m_valid: slot %0d got %b want 1", k, m_axis_valid); end
      n_cmp++; if (m_axis_data !== 16'h1000 + 16'(e)) begin n_err++; $display("FAIL rr_m_data: slot %0d got %h want %h", k, m_axis_data, 16'h1000 + 16'(e)); end
      n_cmp++; if (grant_idx !== 2'(e)) begin n_err++; $display("FAIL rr_grant_idx: slot %0d got %0d want %0d", k, grant_idx, e); end
    end
    n_cmp++; if (underrun_cnt !== 16'd0) begin n_err++; $display("FAIL rr_underrun: got %0d want 0", underrun_cnt); end
    n_cmp++; if (overrun_cnt !== 16'd0) begin n_err++; $display("FAIL rr_overrun: got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_masking();
    logic [3:0] rdy; int at, e; bit ok;
    src_mask = 4'b1010; ready_seen = 4'h0;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 1 : 3;
      wait_grant(20, rdy, at, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL mask_timeout: slot %0d got no grant want grant", k); end
      n_cmp++; if (rdy !== (4'b0001 << e)) begin n_err++; $display("FAIL mask_ready: slot %0d got %b want %b", k, rdy, 4'b0001 << e); end
      n_cmp++; if (at - last_at !== 8) begin n_err++; $display("FAIL mask_period: slot %0d got %0d want 8", k, at - last_at); end
      last_at = at;
      @(negedge mclk);
      n_cmp++; if (grant_idx !== 2'(e)) begin n_err++; $display("FAIL mask_grant_idx: slot %0d got %0d want %0d", k, grant_idx, e); end
    end
    n_cmp++; if ((ready_seen & 4'b0101) !== 4'h0) begin n_err++; $display("FAIL mask_blocked_ready: got %b want 0000", ready_seen & 4'b0101); end
  endtask

  task automatic test_underrun();
    logic [3:0] rdy; int at; bit ok;
    s_axis_valid = 4'h0; src_mask = 4'hF;
    repeat (3) @(negedge mclk);
    valid_seen = 1'b0;
    repeat (37) @(negedge mclk);
    n_cmp++; if (underrun_cnt !== 16'd5) begin n_err++; $display("FAIL under_count: got %0d want 5", underrun_cnt); end
    n_cmp++; if (valid_seen !== 1'b0) begin n_err++; $display("FAIL under_m_valid: got %b want 0", valid_seen); end
    s_axis_valid = 4'b0100;
    wait_grant(20, rdy, at, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL under_timeout: got no grant want grant"); end
    n_cmp++; if (rdy !== 4'b0100) begin n_err++; $display("FAIL under_ready: got %b want 0100", rdy); end
    n_cmp++; if (at - last_at !== 48) begin n_err++; $display("FAIL under_period: got %0d want 48", at - last_at); end
    last_at = at;
    @(negedge mclk);
    n_cmp++; if (grant_idx !== 2'd2) begin n_err++; $display("FAIL under_grant_idx: got %0d want 2", grant_idx); end
    n_cmp++; if (m_axis_data !== 16'h1002) begin n_err++; $display("FAIL under_m_data: got %h want 1002", m_axis_data); end
  endtask

  task automatic test_overrun();
    logic [3:0] rdy; int at; bit ok, stable;
    s_axis_valid = 4'hF;
    repeat (3) @(negedge mclk);
    ready_delay = 20;
    wait_grant(20, rdy, at, ok);
    n_cmp++; if (rdy !== 4'b1000) begin n_err++; $display("FAIL over_first_ready: got %b want 1000", rdy); end
    last_at = at;
    @(negedge mclk);
    n_cmp++; if (m_axis_valid !== 1'b1 || m_axis_data !== 16'h1003) begin n_err++; $display("FAIL over_m_first: got %b/%h want 1/1003", m_axis_valid, m_axis_data); end
    stable = 1'b1;
    repeat (19) begin
      @(negedge mclk);
      if (m_axis_valid !== 1'b1 || m_axis_data !== 16'h1003) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL over_stable: got unstable want stable valid/data"); end
    ready_delay = 2;
    wait_grant(20, rdy, at, ok);
    n_cmp++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL over_next_ready: got %b want 0001", rdy); end
    n_cmp++; if (at - last_at !== 24) begin n_err++; $display("FAIL over_period: got %0d want 24", at - last_at); end
    n_cmp++; if (overrun_cnt !== 16'd2) begin n_err++; $display("FAIL over_count: got %0d want 2", overrun_cnt); end
    last_at = at;
    @(negedge mclk);
    n_cmp++; if (m_axis_data !== 16'h1000) begin n_err++; $display("FAIL over_next_data: got %h want 1000", m_axis_data); end
  endtask

  task automatic test_en_drop();
    logic [3:0] rdy; int at; bit ok, fell, bad;
    ready_delay = 5;
    wait_grant(20, rdy, at, ok);
    n_cmp++; if (rdy !== 4'b0010) begin n_err++; $display("FAIL endrop_ready: got %b want 0010", rdy); end
    @(negedge mclk);
    en = 1'b0;
    fell = 1'b0; bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge mclk);
      if (!m_axis_valid) begin fell = 1'b1; break; end
      if (dac_en !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (!fell) begin n_err++; $display("FAIL endrop_complete: got valid stuck want accepted"); end
    n_cmp++; if (bad) begin n_err++; $display("FAIL endrop_dac_en_hold: got 0 want 1 during send"); end
    n_cmp++; if (dac_en !== 1'b0) begin n_err++; $display("FAIL endrop_dac_en_fall: got %b want 0", dac_en); end
    ready_seen = 4'h0; valid_seen = 1'b0;
    repeat (24) @(negedge mclk);
    n_cmp++; if (ready_seen !== 4'h0 || valid_seen !== 1'b0) begin n_err++; $display("FAIL endrop_no_slot: got %b/%b want 0000/0", ready_seen, valid_seen); end
    n_cmp++; if (underrun_cnt !== 16'd5 || overrun_cnt !== 16'd2) begin n_err++; $display("FAIL endrop_counters: got %0d/%0d want 5/2", underrun_cnt, overrun_cnt); end
  endtask

  task automatic test_reset_mid_send();
    logic [3:0] rdy; int at, c0; bit ok;
    ready_delay = 20;
    en = 1'b1; c0 = cyc;
    @(negedge mclk);
    n_cmp++; if (dac_en !== 1'b1) begin n_err++; $display("FAIL rms_dac_en_lag: got %b want 1", dac_en); end
    wait_grant(20, rdy, at, ok);
    n_cmp++; if (rdy !== 4'b0100) begin n_err++; $display("FAIL rms_ready: got %b want 0100", rdy); end
    n_cmp++; if (at - c0 !== 7) begin n_err++; $display("FAIL rms_first_tick: got %0d want 7", at - c0); end
    @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0; c0 = cyc;
    n_cmp++; if (m_axis_valid !== 1'b0) begin n_err++; $display("FAIL rms_m_valid: got %b want 0", m_axis_valid); end
    n_cmp++; if (underrun_cnt !== 16'd0 || overrun_cnt !== 16'd0) begin n_err++; $display("FAIL rms_counters: got %0d/%0d want 0/0", underrun_cnt, overrun_cnt); end
    n_cmp++; if (grant_idx !== 2'd0 || m_axis_data !== 16'h0 || dac_en !== 1'b0) begin n_err++; $display("FAIL rms_outputs: got %0d/%h/%b want 0/0000/0", grant_idx, m_axis_data, dac_en); end
    ready_delay = 2;
    wait_grant(20, rdy, at, ok);
    n_cmp++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL rms_regrant: got %b want 0001", rdy); end
    n_cmp++; if (at - c0 !== 7) begin n_err++; $display("FAIL rms_regrant_tick: got %0d want 7", at - c0); end
    @(negedge mclk);
    n_cmp++; if (m_axis_data !== 16'h1000 || grant_idx !== 2'd0) begin n_err++; $display("FAIL rms_regrant_data: got %h/%0d want 1000/0", m_axis_data, grant_idx); end
  endtask

  initial begin
    for (int i = 0; i < N_SRC; i++) s_axis_data[i*DATA_W +: DATA_W] = 16'h1000 + 16'(i);
    test_reset();
    test_round_robin();
    test_masking();
    test_underrun();
    test_overrun();
    test_en_drop();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
